cla_subtractor_pipe: RTL and testbench

- Pipelined borrow-lookahead subtractor. Computes a - b - bin, which is the inverse of the carry-lookahead adder.
- Operands enter through a valid/ready handshake. Results leave through a second valid/ready handshake.
- Used as the subtract path beside the adder datapath, and as a loopback check: (a + b) - b returns a.
- Two register stages give a latency of 2 cycles. Full throughput is one operation per clock.

---
 rtl/cla_subtractor_pipe.sv | 137 +++++++++++++
 tb/tb_cla_subtractor_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined borrow-lookahead subtractor: diff = a - b - bin.
// The subtraction is done as a + ~b + ~bin. The final carry is inverted to give the borrow.
// Stage 1 forms group generate/propagate terms and both conditional partial sums.
// Stage 2 resolves the group carries and selects the sums.
module cla_subtractor_pipe #(
  parameter int WIDTH = 4,
  parameter int GROUP = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
);

  localparam int NGRP = WIDTH / GROUP;

  // Group generate/propagate from bit-level g = a & ~b and p = a | ~b; returns {G, P}.
  function automatic logic [1:0] grp_gp(input logic [GROUP-1:0] ga,
                                        input logic [GROUP-1:0] gnb);
    logic gen;
    logic prp;
    gen = 1'b0;
    prp = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      gen = (ga[i] & gnb[i]) | ((ga[i] | gnb[i]) & gen);
      prp = prp & (ga[i] | gnb[i]);
    end
    return {gen, prp};
  endfunction

  // Group-local sum of a + ~b for an assumed carry-in.
  function automatic logic [GROUP-1:0] part_sum(input logic [GROUP-1:0] ga,
                                                input logic [GROUP-1:0] gnb,
                                                input logic             cin);
    return ga + gnb + GROUP'(cin);
  endfunction

  logic [WIDTH-1:0]            bn;
  logic [NGRP-1:0]             gg_c, gp_c;
  logic [NGRP-1:0][GROUP-1:0]  s0_c, s1_c;

  logic [NGRP-1:0]             gg_p1, gp_p1;
  logic [NGRP-1:0][GROUP-1:0]  s0_p1, s1_p1;
  logic                        c0_p1;
  logic                        vld_p1;
  logic                        vld_p2;

  logic [WIDTH-1:0]            diff_c;
  logic                        bout_c;
  logic                        zero_c;

  logic                        adv1, adv2;

  assign bn        = ~b;
  assign adv2      = !vld_p2 | out_ready;
  assign adv1      = !vld_p1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_p2;

  // Per-group generate/propagate and both candidate partial sums from the raw operands.
  always_comb begin
    gg_c = '0;
    gp_c = '0;
    s0_c = '0;
    s1_c = '0;
    for (int k = 0; k < NGRP; k++) begin
      {gg_c[k], gp_c[k]} = grp_gp(a[k*GROUP +: GROUP], bn[k*GROUP +: GROUP]);
      s0_c[k] = part_sum(a[k*GROUP +: GROUP], bn[k*GROUP +: GROUP], 1'b0);
      s1_c[k] = part_sum(a[k*GROUP +: GROUP], bn[k*GROUP +: GROUP], 1'b1);
    end
  end

  // ---- stage 1 boundary ----

  // Stage 1 datapath register; contents only matter when vld_p1 is set.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      gg_p1 <= gg_c;
      gp_p1 <= gp_c;
      s0_p1 <= s0_c;
      s1_p1 <= s1_c;
      c0_p1 <= ~bin;
    end
  end

  // Ripple the group carries through the lookahead terms and pick each group's sum.
  always_comb begin
    logic c;
    c      = c0_p1;
    diff_c = '0;
    for (int k = 0; k < NGRP; k++) begin
      diff_c[k*GROUP +: GROUP] = c ? s1_p1[k] : s0_p1[k];
      c = gg_p1[k] | (gp_p1[k] & c);
    end
    bout_c = ~c;
    zero_c = (diff_c == '0);
  end

  // ---- stage 2 boundary ----

  // Result register; it holds while the downstream stalls and clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
    end else if (adv2 && vld_p1) begin
      diff <= diff_c;
      bout <= bout_c;
      zero <= zero_c;
    end
  end

  // Pipeline occupancy and the completed-operation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      op_count <= '0;
    end else begin
      if (adv1) vld_p1 <= in_valid;
      if (adv2) vld_p2 <= vld_p1;
      if (vld_p2 && out_ready) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Directed bench for cla_subtractor_pipe with a scoreboard queue of expected results.
module tb_cla_subtractor_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] diff;
  logic       bout;
  logic       zero;
  logic [7:0] op_count;

  int errors = 0;
  int checks = 0;
  int n_out = 0;
  int cyc = 0;
  int first_fire = -1;
  int last_fire = -1;
  bit acc;
  logic [4:0] exp_q[$];

  cla_subtractor_pipe #(.WIDTH(4), .GROUP(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Behavioural reference: unsigned a - b - bin over 5 bits, bit 4 is the borrow.
  function automatic logic [4:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mbin);
    return {1'b0, ma} - {1'b0, mb} - {4'b0, mbin};
  endfunction

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    logic [4:0] e;
    acc = 1'b0;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      n_out = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("diff", diff, e[3:0]);
          chk("bout", bout, e[4]);
          chk("zero", zero, (e[3:0] == 4'd0));
        end
        n_out++;
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
      end else if (out_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("hold_diff", diff, e[3:0]);
        chk("hold_bout", bout, e[4]);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, bin));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [3:0] sa, input logic [3:0] sb, input logic sbin);
    int n;
    a = sa; b = sb; bin = sbin; in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("accept_timeout", 32'(acc), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      cycle();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_zero", zero, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // 1 - 1 - 0 = 0 with zero flag
    send(4'd1, 4'd1, 1'b0);
    drain();
    chk("op_count_1", op_count, 1);

    // Borrow and no-borrow cases
    send(4'd0, 4'd5, 1'b1);
    send(4'd15, 4'd1, 1'b0);
    drain();
    chk("op_count_3", op_count, 3);

    // Six back-to-back operations give six consecutive results
    first_fire = -1;
    last_fire = -1;
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); bin = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      cycle();
      chk("b2b_accept", 32'(acc), 1);
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_span", last_fire - first_fire, 5);
    chk("op_count_9", op_count, 8'(n_out));

    // Backpressure: two accepted, then in_ready drops and the result holds
    out_ready = 1'b0;
    send(4'd9, 4'd3, 1'b0);
    send(4'd2, 4'd7, 1'b1);
    chk("bp_in_ready_low", in_ready, 0);
    a = 4'd12; b = 4'd12; bin = 1'b1; in_valid = 1'b1;
    cycle();
    cycle();
    chk("bp_not_accepted", 32'(acc), 0);
    chk("bp_queue", exp_q.size(), 2);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_back", in_ready, 1);
    cycle();
    chk("bp_third_accepted", 32'(acc), 1);
    in_valid = 1'b0;
    drain();
    chk("bp_op_count", op_count, 8'(n_out));

    // Reset with both stages full discards everything
    out_ready = 1'b0;
    send(4'd4, 4'd1, 1'b0);
    send(4'd6, 4'd2, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("mid_rst_no_stale", op_count, 0);

    // Loopback (x + y) - y == x for all pairs, 256 results wrap the counter
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a = 4'(x + y); b = 4'(y); bin = 1'b0; in_valid = 1'b1;
        cycle();
        if (acc) begin
          exp_q.pop_back();
          exp_q.push_back({((x + y) > 15) ? 1'b1 : 1'b0, 4'(x)});
        end else begin
          chk("loop_accept", 32'(acc), 1);
        end
      end
    end
    in_valid = 1'b0;
    drain();
    chk("loop_count", n_out, 256);
    chk("op_count_wrap", op_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
